recovery_sequencer: RTL and testbench

Multi-cycle branch-mispredict recovery controller that sits beside the retire stage. It is triggered by the retire stage's mispredict pulse and then sequences the rest of the machine:
- flushes the ROB, RS and LSQ, and restores the freelist;
- copies the architected map into the speculative map table in chunks;
- waits for in-flight FU/memory ops to drain;
- issues a single fetch redirect.

Dispatch and retire are held off for the whole recovery.

---
 rtl/recovery_sequencer_if.sv | 45 ++++
 rtl/recovery_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_recovery_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/recovery_sequencer_if.sv
// Retire-side handshake bundle for the branch-mispredict recovery sequencer.
// The sequencer connects through the slave modport; the surrounding pipeline uses master.
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef ROB_SZ
`define ROB_SZ 64
`endif

interface recovery_sequencer_if #(
    parameter int ARCH_COUNT = `ARCH_REG_SZ,
    parameter int ROB_IDX_W  = $clog2(`ROB_SZ),
    parameter int ADDR_W     = 32,
    parameter int OPS_W      = $clog2(`ROB_SZ) + 1
);
    logic                  rob_mispredict;
    logic [ROB_IDX_W-1:0]  rob_mispred_idx;
    logic [ADDR_W-1:0]     mispred_target;
    logic [OPS_W-1:0]      outstanding_ops;

    logic                  flush_all;
    logic [ROB_IDX_W-1:0]  flush_rob_idx;
    logic                  freelist_restore;
    logic [ARCH_COUNT-1:0] map_copy_mask;
    logic                  fetch_redirect;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  dispatch_stall;
    logic                  retire_block;
    logic                  busy;
    logic                  overlap_err;

    modport master (
        output rob_mispredict, rob_mispred_idx, mispred_target, outstanding_ops,
        input  flush_all, flush_rob_idx, freelist_restore, map_copy_mask,
               fetch_redirect, redirect_pc, dispatch_stall, retire_block,
               busy, overlap_err
    );

    modport slave (
        input  rob_mispredict, rob_mispred_idx, mispred_target, outstanding_ops,
        output flush_all, flush_rob_idx, freelist_restore, map_copy_mask,
               fetch_redirect, redirect_pc, dispatch_stall, retire_block,
               busy, overlap_err
    );
endinterface

// File: rtl/recovery_sequencer.sv
// Branch-mispredict recovery: flush, chunked arch->spec map copy, drain, single redirect.
// Optional perf counters (recovery_count, recovery_cycles) are built when RECOVERY_PERF_EN is defined.
module recovery_sequencer #(
    parameter int ARCH_COUNT     = `ARCH_REG_SZ,
    parameter int COPY_PER_CYCLE = 8,
    parameter int ROB_SZ         = `ROB_SZ,
    parameter int ADDR_W         = 32
`ifdef RECOVERY_PERF_EN
    ,
    parameter int CNT_W          = 16
`endif
) (
    input  logic clock,
    input  logic reset,
    recovery_sequencer_if.slave bus
`ifdef RECOVERY_PERF_EN
    ,
    output logic [CNT_W-1:0] recovery_count,
    output logic [CNT_W-1:0] recovery_cycles
`endif
);
    localparam int ROB_IDX_W  = $clog2(ROB_SZ);
    localparam int OPS_W      = $clog2(ROB_SZ) + 1;
    localparam int NUM_CHUNKS = (ARCH_COUNT + COPY_PER_CYCLE - 1) / COPY_PER_CYCLE;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [CHUNK_W-1:0] CHUNK_ZERO = CHUNK_W'(0);
    localparam logic [CHUNK_W-1:0] CHUNK_ONE  = CHUNK_W'(1);
    localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(NUM_CHUNKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_COPY     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_REDIRECT = 3'd4
    } state_t;

    state_t                state_r;
    logic [CHUNK_W-1:0]    chunk_r;
    logic [ROB_IDX_W-1:0]  idx_r;
    logic [ADDR_W-1:0]     pc_r;
    logic                  flush_all_r;
    logic                  freelist_restore_r;
    logic [ARCH_COUNT-1:0] map_copy_mask_r;
    logic                  fetch_redirect_r;
    logic                  busy_r;
    logic                  overlap_err_r;
    logic                  ops_idle_s;

    // Chunk k covers entries [k*CPC, (k+1)*CPC); the loop bound clips the last partial chunk.
    function automatic logic [ARCH_COUNT-1:0] chunk_mask(input logic [CHUNK_W-1:0] k);
        logic [ARCH_COUNT-1:0] m;
        int lo;
        lo = int'(k) * COPY_PER_CYCLE;
        m  = '0;
        for (int i = 0; i < ARCH_COUNT; i++) begin
            m[i] = (i >= lo) && (i < lo + COPY_PER_CYCLE);
        end
        return m;
    endfunction

    assign ops_idle_s = (bus.outstanding_ops == {OPS_W{1'b0}});

    // Recovery FSM; each output register is loaded with the value for the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            chunk_r            <= CHUNK_ZERO;
            idx_r              <= '0;
            pc_r               <= '0;
            flush_all_r        <= 1'b0;
            freelist_restore_r <= 1'b0;
            map_copy_mask_r    <= '0;
            fetch_redirect_r   <= 1'b0;
            busy_r             <= 1'b0;
            overlap_err_r      <= 1'b0;
        end else begin
            flush_all_r        <= 1'b0;
            freelist_restore_r <= 1'b0;
            map_copy_mask_r    <= '0;
            fetch_redirect_r   <= 1'b0;

            // A trigger outside IDLE (including the REDIRECT cycle) is dropped and flagged.
            if ((state_r != ST_IDLE) && bus.rob_mispredict) begin
                overlap_err_r <= 1'b1;
            end else begin
                overlap_err_r <= overlap_err_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.rob_mispredict) begin
                        state_r            <= ST_FLUSH;
                        idx_r              <= bus.rob_mispred_idx;
                        pc_r               <= bus.mispred_target;
                        flush_all_r        <= 1'b1;
                        freelist_restore_r <= 1'b1;
                        busy_r             <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_r         <= ST_COPY;
                    chunk_r         <= CHUNK_ZERO;
                    map_copy_mask_r <= chunk_mask(CHUNK_ZERO);
                    busy_r          <= 1'b1;
                end
                ST_COPY: begin
                    busy_r <= 1'b1;
                    if (chunk_r == CHUNK_LAST) begin
                        state_r <= ST_DRAIN;
                        chunk_r <= CHUNK_ZERO;
                    end else begin
                        state_r         <= ST_COPY;
                        chunk_r         <= chunk_r + CHUNK_ONE;
                        map_copy_mask_r <= chunk_mask(chunk_r + CHUNK_ONE);
                    end
                end
                ST_DRAIN: begin
                    busy_r <= 1'b1;
                    if (ops_idle_s) begin
                        state_r          <= ST_REDIRECT;
                        fetch_redirect_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_REDIRECT: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    chunk_r <= CHUNK_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush_all        = flush_all_r;
    assign bus.flush_rob_idx    = idx_r;
    assign bus.freelist_restore = freelist_restore_r;
    assign bus.map_copy_mask    = map_copy_mask_r;
    assign bus.fetch_redirect   = fetch_redirect_r;
    assign bus.redirect_pc      = pc_r;
    assign bus.busy             = busy_r;
    assign bus.retire_block     = busy_r;
    assign bus.overlap_err      = overlap_err_r;
    // Stall already in the trigger cycle so the mispredicting group never renames.
    assign bus.dispatch_stall   = busy_r | (~busy_r & bus.rob_mispredict & ~reset);

`ifdef RECOVERY_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] recovery_count_r;
    logic [CNT_W-1:0] recovery_cycles_r;

    // Saturating counters: one count per FLUSH visit, one cycle per busy cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            recovery_count_r  <= '0;
            recovery_cycles_r <= '0;
        end else begin
            if ((state_r == ST_FLUSH) && (recovery_count_r != {CNT_W{1'b1}})) begin
                recovery_count_r <= recovery_count_r + CNT_ONE;
            end else begin
                recovery_count_r <= recovery_count_r;
            end
            if (busy_r && (recovery_cycles_r != {CNT_W{1'b1}})) begin
                recovery_cycles_r <= recovery_cycles_r + CNT_ONE;
            end else begin
                recovery_cycles_r <= recovery_cycles_r;
            end
        end
    end

    assign recovery_count  = recovery_count_r;
    assign recovery_cycles = recovery_cycles_r;
`endif
endmodule

// File: tb/tb_recovery_sequencer.sv
// Self-checking bench: two sequencers (COPY_PER_CYCLE 8 and 12) share directed + random
// stimulus and are compared every cycle against a timeline model of each recovery.
module tb_recovery_sequencer;
    localparam int NCYC = 2500;

    logic        clock;
    logic        reset;
    logic        mp;
    logic [5:0]  idx;
    logic [31:0] tgt;
    logic [6:0]  ops;

    int checks   = 0;
    int failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    recovery_sequencer_if #(.ARCH_COUNT(32), .ROB_IDX_W(6), .ADDR_W(32), .OPS_W(7)) ifa ();
    recovery_sequencer_if #(.ARCH_COUNT(32), .ROB_IDX_W(6), .ADDR_W(32), .OPS_W(7)) ifb ();

    assign ifa.rob_mispredict  = mp;
    assign ifa.rob_mispred_idx = idx;
    assign ifa.mispred_target  = tgt;
    assign ifa.outstanding_ops = ops;
    assign ifb.rob_mispredict  = mp;
    assign ifb.rob_mispred_idx = idx;
    assign ifb.mispred_target  = tgt;
    assign ifb.outstanding_ops = ops;

`ifdef RECOVERY_PERF_EN
    logic [15:0] cnt_a, cyc_a, cnt_b, cyc_b;
`endif

    recovery_sequencer #(.ARCH_COUNT(32), .COPY_PER_CYCLE(8), .ROB_SZ(64), .ADDR_W(32)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
`ifdef RECOVERY_PERF_EN
        ,
        .recovery_count  (cnt_a),
        .recovery_cycles (cyc_a)
`endif
    );

    recovery_sequencer #(.ARCH_COUNT(32), .COPY_PER_CYCLE(12), .ROB_SZ(64), .ADDR_W(32)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
`ifdef RECOVERY_PERF_EN
        ,
        .recovery_count  (cnt_b),
        .recovery_cycles (cyc_b)
`endif
    );

    // Reference model: each recovery is a timeline anchored at its trigger cycle.
    int          cpc    [2] = '{8, 12};
    bit          active [2];
    int          trig   [2];
    int          redir  [2];
    bit          ovl    [2];
    logic [5:0]  lidx   [2];
    logic [31:0] lpc    [2];
    int          pcnt   [2];
    int          pcyc   [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int n_chunks(input int d);
        return (32 + cpc[d] - 1) / cpc[d];
    endfunction

    function automatic logic [63:0] chunk_bits(input int d, input int k);
        int lo, hi;
        lo = k * cpc[d];
        hi = (lo + cpc[d] > 32) ? 32 : lo + cpc[d];
        return ((64'd1 << hi) - 64'd1) ^ ((64'd1 << lo) - 64'd1);
    endfunction

    function automatic bit busy_exp(input int d, input int c);
        return active[d] && (c > trig[d]) && ((redir[d] < 0) || (c <= redir[d]));
    endfunction

    task automatic check_dut(input int d, input int c);
        logic        o_fa, o_fr, o_rd, o_ds, o_rb, o_bz, o_ov;
        logic [5:0]  o_idx;
        logic [31:0] o_pc, o_mask;
        logic [63:0] e_mask;
        bit          b, fl;
        string       p;
        if (d == 0) begin
            o_fa = ifa.flush_all; o_fr = ifa.freelist_restore; o_rd = ifa.fetch_redirect;
            o_ds = ifa.dispatch_stall; o_rb = ifa.retire_block; o_bz = ifa.busy;
            o_ov = ifa.overlap_err; o_idx = ifa.flush_rob_idx; o_pc = ifa.redirect_pc;
            o_mask = ifa.map_copy_mask;
        end else begin
            o_fa = ifb.flush_all; o_fr = ifb.freelist_restore; o_rd = ifb.fetch_redirect;
            o_ds = ifb.dispatch_stall; o_rb = ifb.retire_block; o_bz = ifb.busy;
            o_ov = ifb.overlap_err; o_idx = ifb.flush_rob_idx; o_pc = ifb.redirect_pc;
            o_mask = ifb.map_copy_mask;
        end
        p  = $sformatf("d%0d.c%0d.", d, c);
        b  = busy_exp(d, c);
        fl = active[d] && (c == trig[d] + 1);
        e_mask = 64'd0;
        if (active[d] && (c >= trig[d] + 2) && (c <= trig[d] + 1 + n_chunks(d)))
            e_mask = chunk_bits(d, c - trig[d] - 2);
        check_val({p, "busy"},             64'(o_bz), 64'(b));
        check_val({p, "retire_block"},     64'(o_rb), 64'(b));
        check_val({p, "dispatch_stall"},   64'(o_ds), 64'(b || (!reset && mp)));
        check_val({p, "flush_all"},        64'(o_fa), 64'(fl));
        check_val({p, "freelist_restore"}, 64'(o_fr), 64'(fl));
        check_val({p, "flush_rob_idx"},    64'(o_idx), 64'(lidx[d]));
        check_val({p, "map_copy_mask"},    64'(o_mask), e_mask);
        check_val({p, "fetch_redirect"},   64'(o_rd), 64'(active[d] && (c == redir[d])));
        check_val({p, "redirect_pc"},      64'(o_pc), 64'(lpc[d]));
        check_val({p, "overlap_err"},      64'(o_ov), 64'(ovl[d]));
`ifdef RECOVERY_PERF_EN
        check_val({p, "recovery_count"},  64'((d == 0) ? cnt_a : cnt_b), 64'(pcnt[d]));
        check_val({p, "recovery_cycles"}, 64'((d == 0) ? cyc_a : cyc_b), 64'(pcyc[d]));
`endif
    endtask

    task automatic advance(input int d, input int c);
        bit b;
        b = busy_exp(d, c);
        if (reset) begin
            active[d] = 1'b0; redir[d] = -1; ovl[d] = 1'b0;
            lidx[d] = 6'd0; lpc[d] = 32'd0; pcnt[d] = 0; pcyc[d] = 0;
        end else begin
            if (active[d] && (c == trig[d] + 1) && (pcnt[d] < 65535)) pcnt[d]++;
            if (b && (pcyc[d] < 65535)) pcyc[d]++;
            if (active[d] && (redir[d] < 0) && (c >= trig[d] + 2 + n_chunks(d)) && (ops == 7'd0))
                redir[d] = c + 1;
            if (active[d] && (redir[d] >= 0) && (c == redir[d]))
                active[d] = 1'b0;
            if (mp && b) begin
                ovl[d] = 1'b1;
            end else if (mp) begin
                active[d] = 1'b1; trig[d] = c; redir[d] = -1;
                lidx[d] = idx; lpc[d] = tgt;
            end
        end
    endtask

    task automatic drive_trig(input logic [5:0] i, input logic [31:0] t);
        mp  = 1'b1;
        idx = i;
        tgt = t;
    endtask

    initial begin
        reset = 1'b1; mp = 1'b0; idx = 6'd0; tgt = 32'd0; ops = 7'd0;
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0; trig[d] = 0; redir[d] = -1; ovl[d] = 1'b0;
            lidx[d] = 6'd0; lpc[d] = 32'd0; pcnt[d] = 0; pcyc[d] = 0;
        end
        @(posedge clock);
        #1;
        for (int c = 0; c < NCYC; c++) begin
            reset = (c <= 2); mp = 1'b0; idx = 6'd0; tgt = 32'd0; ops = 7'd0;
            case (c)
                5:   drive_trig(6'd5, 32'h0000_1000);
                20:  drive_trig(6'd7, 32'h0000_2000);
                45:  drive_trig(6'd1, 32'h0000_3000);
                48:  drive_trig(6'd9, 32'h0000_9990);
                70:  drive_trig(6'd2, 32'h0000_5000);
                73:  reset = 1'b1;
                80:  drive_trig(6'd4, 32'h0000_4000);
                100: drive_trig(6'd11, 32'h0000_6000);
                108: drive_trig(6'd12, 32'h0000_7000);
                115: drive_trig(6'd13, 32'h0000_8000);
                default: begin
                    if (c >= 130) begin
                        reset = ($urandom_range(0, 299) == 0);
                        if (!reset && ($urandom_range(0, 9) == 0))
                            drive_trig(6'($urandom_range(0, 63)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
                        if ($urandom_range(0, 9) >= 6) ops = 7'($urandom_range(1, 7));
                    end
                end
            endcase
            if (c >= 26 && c <= 29) ops = 7'd3;
            @(negedge clock);
            if (c > 0) begin
                check_dut(0, c);
                check_dut(1, c);
            end
            advance(0, c);
            advance(1, c);
            @(posedge clock);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
